wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//   Shares the register file's single write port between NUM_REQ writeback requesters (ALU, LSU, MUL/DIV).
//   Each requester uses a valid/ready handshake. The block grants one requester per cycle and drives a registered wen/rd_waddr/rd_wdata into the register file.
//   It also keeps a per-register pending scoreboard. ID uses the scoreboard for RAW-hazard stalls.
// PARAMETERS
//   NUM_REQ  3   number of writeback requesters; index 0 is the highest fixed priority
//   XLEN     32  data width (RegBus)
//   AW       5   register address width (RegAddrBus); 2**AW registers
// PORTS
//   clk         in   1             clock; all state updates on posedge
//   rst         in   1             synchronous reset, active-high
//   req_valid   in   NUM_REQ       requester i holds a write
//   req_ready   out  NUM_REQ       requester i accepted this cycle (combinational)
//   req_rd      in   NUM_REQ*AW    destination register, slice i
//   req_data    in   NUM_REQ*XLEN  write data, slice i
//   issue_valid in   1             ID issued an instruction that writes issue_rd
//   issue_rd    in   AW            destination of the issued instruction
//   rs1_addr    in   AW            ID source 1 lookup
//   rs2_addr    in   AW            ID source 2 lookup
//   rs1_busy    out  1             rs1_addr has a pending write (combinational)
//   rs2_busy    out  1             rs2_addr has a pending write (combinational)
//   busy_vec    out  2**AW         raw scoreboard; bit 0 is always 0
//   wen         out  1             register-file write enable (registered)
//   rd_waddr    out  AW            register-file write address (registered)
//   rd_wdata    out  XLEN          register-file write data (registered)
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     - wen=0, rd_waddr=0, rd_wdata=0, busy_vec=0, rr pointer=0.
//     - While rst=1, req_ready=0 and rs*_busy=0.
//     - Reset mid-transfer discards any granted-but-unwritten data.
//   Handshake:
//     - Transfer i occurs when req_valid[i] && req_ready[i].
//     - After asserting valid, a requester holds valid, rd and data stable until ready.
//     - req_ready depends on req_valid and state, never on ready from elsewhere.
//   rd==0 requests:
//     - req_ready[i]=1 in the same cycle, independent of arbitration.
//     - They never produce wen and never consume the grant slot.
//   Arbitration:
//     - Among valid requesters with rd!=0, exactly one is granted per cycle.
//     - The grant is one-hot on req_ready.
//   Latency: a grant in cycle N gives wen=1 in cycle N+1, with rd_waddr/rd_wdata latched from the winner. wen=0 in any cycle after a grantless cycle.
//   Throughput: one write per cycle, no bubbles; back-to-back grants allowed.
//   Scoreboard:
//     - At posedge, busy[issue_rd] is set when issue_valid && issue_rd!=0.
//     - At the grant edge, busy[granted rd] is cleared.
//     - Set and clear on the same register in the same edge: set wins (a newer producer is in flight).
//   Busy lookup:
//     - rsX_busy = busy[rsX_addr], and is 0 for address 0.
//     - The register file forwards wen data, so a register being written in cycle N+1 already reads as not busy.
//   No ordering check between requesters: ID guarantees a single in-flight producer per rd via the stall.
// CONFIGURATION
//   WB_ARB_RR_EN defined:
//     - Round-robin arbitration. The pointer p marks the highest-priority index; search order is p, p+1, ... mod NUM_REQ.
//     - After a grant to i, p <= (i+1) mod NUM_REQ. With no grant, p holds.
//   WB_ARB_RR_EN undefined: fixed priority, lowest index wins; the pointer register is not built.
// STRUCTURE
//   Shared package/defines: XLEN/AW widths (RegBus, RegAddrBus), ZeroReg, ZeroWord, and requester index constants (WB_REQ_ALU=0, WB_REQ_LSU=1, WB_REQ_MDU=2).
//   One sub-module, wb_rr_arbiter: request vector -> one-hot grant. It contains the pointer under WB_ARB_RR_EN.
//   Scoreboard, output register and rd==0 filtering stay in wb_arbiter.
// TESTING
//   1. rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, wen=0, busy_vec=0; outputs identical after rst drops with no valid.
//   2. Only req1 valid, rd=5, data=0xDEADBEEF in cycle N -> req_ready=3'b010 in N; wen=1, rd_waddr=5, rd_wdata=0xDEADBEEF in N+1.
//   3. All three valid with rd=1,2,3, held for 3 cycles:
//      - RR: grants 0,1,2.
//      - Fixed priority, held: grants 0,0,0 and req1/req2 starve.
//   4. req2 valid with rd=0 while req0 valid with rd=7 -> both ready in the same cycle; only one write (rd 7) next cycle.
//   5. issue_valid with issue_rd=9 -> rs1_busy=1 for rs1_addr=9; grant rd=9 -> busy clears; the same edge with issue_rd=9 again keeps busy=1.
//   6. Assert rst in the cycle after a grant -> wen=0 the next cycle and busy cleared; no stale write appears afterwards.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, zero constants and writeback requester indices for the
// register-file writeback arbiter.
package wb_arbiter_pkg;

   localparam int unsigned WB_XLEN    = 32;
   localparam int unsigned WB_AW      = 5;
   localparam int unsigned WB_NUM_REQ = 3;

   typedef logic [WB_XLEN-1:0] RegBus;
   typedef logic [WB_AW-1:0]   RegAddrBus;

   localparam RegAddrBus ZeroReg  = '0;
   localparam RegBus     ZeroWord = '0;

   localparam int unsigned WB_REQ_ALU = 0;
   localparam int unsigned WB_REQ_LSU = 1;
   localparam int unsigned WB_REQ_MDU = 2;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Request vector -> one-hot grant.
// WB_ARB_RR_EN defined  : round-robin; a pointer marks the highest-priority index.
// WB_ARB_RR_EN undefined: fixed priority, lowest index wins, no state.
module wb_rr_arbiter #(
   parameter int unsigned N = 3
)(
`ifdef WB_ARB_RR_EN
   input  logic         i_clk,
   input  logic         i_rst,
`endif
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant
);

`ifdef WB_ARB_RR_EN
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_win;
   logic [PW-1:0] w_ptr_nxt;

   // Scan p, p+1, ... mod N; the first requester found is granted.
   always_comb begin
      int unsigned idx;
      logic [PW-1:0] sel;
      logic found;
      o_grant = '0;
      w_win   = '0;
      idx     = 0;
      sel     = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(r_ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = PW'(idx);
         if (!found && i_req[sel]) begin
            o_grant[sel] = 1'b1;
            w_win        = sel;
            found        = 1'b1;
         end
      end
      w_ptr_nxt = (32'(w_win) + 1 >= N) ? '0 : w_win + 1'b1;
   end

   // Pointer moves just past the winner; holds when nothing is granted.
   always_ff @(posedge i_clk) begin
      if (i_rst)       r_ptr <= '0;
      else if (|i_req) r_ptr <= w_ptr_nxt;
   end
`else
   // Lowest asserted index wins.
   always_comb begin
      logic found;
      o_grant = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && i_req[k]) begin
            o_grant[k] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port among
// NUM_REQ valid/ready requesters and tracks pending writes per register.
// Arbitration mode selected by WB_ARB_RR_EN (see wb_rr_arbiter).
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = WB_NUM_REQ,
   parameter int unsigned XLEN    = WB_XLEN,
   parameter int unsigned AW      = WB_AW
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*AW-1:0]   req_rd,
   input  logic [NUM_REQ*XLEN-1:0] req_data,
   input  logic                    issue_valid,
   input  logic [AW-1:0]           issue_rd,
   input  logic [AW-1:0]           rs1_addr,
   input  logic [AW-1:0]           rs2_addr,
   output logic                    rs1_busy,
   output logic                    rs2_busy,
   output logic [2**AW-1:0]        busy_vec,
   output logic                    wen,
   output logic [AW-1:0]           rd_waddr,
   output logic [XLEN-1:0]         rd_wdata
);

   logic [NUM_REQ-1:0] w_zero_rd;
   logic [NUM_REQ-1:0] w_arb_req;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_any_grant;
   logic [AW-1:0]      w_win_rd;
   logic [XLEN-1:0]    w_win_data;
   logic [2**AW-1:0]   w_busy_nxt;

   logic [2**AW-1:0]   r_busy;
   logic               r_wen;
   logic [AW-1:0]      r_waddr;
   logic [XLEN-1:0]    r_wdata;

   wb_rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
`ifdef WB_ARB_RR_EN
      .i_clk   (clk),
      .i_rst   (rst),
`endif
      .i_req   (w_arb_req),
      .o_grant (w_grant)
   );

   // rd==0 requests bypass arbitration; nothing is offered during reset.
   always_comb begin
      w_zero_rd = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_zero_rd[i] = (req_rd[i*AW +: AW] == '0);
      end
      w_arb_req = rst ? '0 : (req_valid & ~w_zero_rd);
      req_ready = rst ? '0 : (w_grant | (req_valid & w_zero_rd));
   end

   // One-hot grant selects the winning rd/data.
   always_comb begin
      w_win_rd   = '0;
      w_win_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_win_rd   = w_win_rd   | req_rd[i*AW +: AW];
            w_win_data = w_win_data | req_data[i*XLEN +: XLEN];
         end
      end
      w_any_grant = |w_grant;
   end

   // Scoreboard update: clear on grant, then set on issue so a newer producer wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_any_grant) w_busy_nxt[w_win_rd] = 1'b0;
      if (issue_valid && issue_rd != '0) w_busy_nxt[issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   // Registered write port and scoreboard state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= '0;
      end else begin
         r_wen  <= w_any_grant;
         r_busy <= w_busy_nxt;
         if (w_any_grant) begin
            r_waddr <= w_win_rd;
            r_wdata <= w_win_data;
         end
      end
   end

   // Busy lookup; bit 0 of the scoreboard is never set.
   always_comb begin
      rs1_busy = rst ? 1'b0 : r_busy[rs1_addr];
      rs2_busy = rst ? 1'b0 : r_busy[rs2_addr];
   end

   assign busy_vec = r_busy;
   assign wen      = r_wen;
   assign rd_waddr = r_waddr;
   assign rd_wdata = r_wdata;

endmodule
